// File: rtl/clk_en_gen_if.sv
`default_nettype none
// ============================================================================
// clk_en_gen_if : config handshake, sync request and enable/lock outputs
// Rev 1.0 : initial release
// ============================================================================
interface clk_en_gen_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 16
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CHAN_W-1:0]   cfg_chan;
  logic [ACC_W-1:0]    cfg_num;
  logic [ACC_W-1:0]    cfg_den;
  logic                sync;
  logic [CHANNELS-1:0] ce_out;
  logic                locked;

  modport master (
    output cfg_valid, cfg_chan, cfg_num, cfg_den, sync,
    input  cfg_ready, ce_out, locked
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_num, cfg_den, sync,
    output cfg_ready, ce_out, locked
  );
endinterface
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// clk_en_gen : CHANNELS fractional-rate clock-enable pulses from one clock,
//              runtime num/den per channel, lock indicator.
//              Define CLK_EN_GEN_READBACK_EN for rd_chan/rd_num/rd_den.
// Rev 1.0 : initial release
// ============================================================================
module clk_en_gen #(
  parameter  int CHANNELS      = 4,
  parameter  int ACC_W         = 16,
  parameter  int SETTLE_CYCLES = 16,
  localparam int CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic        refclk,
  input  logic        rst_n,
  clk_en_gen_if.slave bus
`ifdef CLK_EN_GEN_READBACK_EN
  ,
  input  logic [CHAN_W-1:0] rd_chan,
  output logic [ACC_W-1:0]  rd_num,
  output logic [ACC_W-1:0]  rd_den
`endif
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_APPLY  = 2'd2
  } state_t;

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE_CYCLES);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_num [CHANNELS];
  logic [ACC_W-1:0]    r_den [CHANNELS];
  logic [ACC_W-1:0]    r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ce;
  logic                r_locked;
  logic [CHAN_W-1:0]   r_sh_chan;
  logic [ACC_W-1:0]    r_sh_num;
  logic [ACC_W-1:0]    r_sh_den;

  logic [ACC_W:0]      w_sum [CHANNELS];
  logic [CHANNELS-1:0] w_act;
  logic [CHANNELS-1:0] w_hit;
  logic                w_ready;
  logic                w_take;
  logic [ACC_W-1:0]    w_new_num;

  // Channel k defaults to 1/2^k, saturating once 2^k no longer fits.
  function automatic logic [ACC_W-1:0] f_rst_den(input int k);
    if (k >= ACC_W) return '1;
    return ACC_W'(1) << k;
  endfunction

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_sum[k] = {1'b0, r_acc[k]} + {1'b0, r_num[k]};
      w_act[k] = (r_num[k] != '0) && (r_den[k] != '0);
      w_hit[k] = w_act[k] && (w_sum[k] >= {1'b0, r_den[k]});
    end
  end

  assign w_ready   = (r_state != ST_APPLY);
  // Out-of-range channels complete the handshake but never leave the state.
  assign w_take    = bus.cfg_valid && w_ready && (32'(bus.cfg_chan) < 32'(CHANNELS));
  assign w_new_num = (r_sh_num > r_sh_den) ? r_sh_den : r_sh_num;

  assign bus.cfg_ready = w_ready;
  assign bus.ce_out    = r_ce;
  assign bus.locked    = r_locked;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SETTLE;
      r_cnt     <= C_SETTLE;
      r_ce      <= '0;
      r_locked  <= 1'b0;
      r_sh_chan <= '0;
      r_sh_num  <= '0;
      r_sh_den  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_num[k] <= ACC_W'(1);
        r_den[k] <= f_rst_den(k);
        r_acc[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_APPLY: begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (CHAN_W'(k) == r_sh_chan) begin
              r_num[k] <= w_new_num;
              r_den[k] <= r_sh_den;
            end
            r_acc[k] <= '0;
          end
          r_ce    <= '0;
          r_cnt   <= C_SETTLE;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE, ST_RUN: begin
          if (w_take) begin
            // Config beats sync; enables are meaningless until relock.
            r_state   <= ST_APPLY;
            r_locked  <= 1'b0;
            r_ce      <= '0;
            r_sh_chan <= bus.cfg_chan;
            r_sh_num  <= bus.cfg_num;
            r_sh_den  <= bus.cfg_den;
            for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
          end else if (r_state == ST_SETTLE) begin
            r_ce <= '0;
            for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
            if (r_cnt == '0) begin
              r_state  <= ST_RUN;
              r_locked <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end else if (bus.sync) begin
            r_ce <= '0;
            for (int k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
          end else begin
            for (int k = 0; k < CHANNELS; k++) begin
              if (w_hit[k]) begin
                r_acc[k] <= ACC_W'(w_sum[k] - {1'b0, r_den[k]});
                r_ce[k]  <= 1'b1;
              end else begin
                r_acc[k] <= w_act[k] ? w_sum[k][ACC_W-1:0] : '0;
                r_ce[k]  <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state  <= ST_SETTLE;
          r_cnt    <= C_SETTLE;
          r_locked <= 1'b0;
          r_ce     <= '0;
        end
      endcase
    end
  end

`ifdef CLK_EN_GEN_READBACK_EN
  logic [ACC_W-1:0] r_rd_num;
  logic [ACC_W-1:0] r_rd_den;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_num <= '0;
      r_rd_den <= '0;
    end else begin
      r_rd_num <= '0;
      r_rd_den <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (CHAN_W'(k) == rd_chan) begin
          r_rd_num <= r_num[k];
          r_rd_den <= r_den[k];
        end
      end
    end
  end

  assign rd_num = r_rd_num;
  assign rd_den = r_rd_den;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
// ============================================================================
// tb_clk_en_gen : self-checking bench for clk_en_gen
// Rev 1.0 : initial release
// ============================================================================
module tb_clk_en_gen;
  localparam int CH = 4;
  localparam int AW = 16;
  localparam int SC = 16;

  logic refclk = 1'b0;
  logic rst_n  = 1'b1;
  logic rst2_n = 1'b1;
  always #5 refclk = ~refclk;

  clk_en_gen_if #(.CHANNELS(CH), .ACC_W(AW)) bus ();
  clk_en_gen_if #(.CHANNELS(3),  .ACC_W(2))  bus2 ();

`ifdef CLK_EN_GEN_READBACK_EN
  logic [1:0]    rd_chan  = '0;
  logic [1:0]    rd2_chan = '0;
  logic [AW-1:0] rd_num, rd_den;
  logic [1:0]    rd2_num, rd2_den;
`endif

  clk_en_gen #(.CHANNELS(CH), .ACC_W(AW), .SETTLE_CYCLES(SC)) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
`ifdef CLK_EN_GEN_READBACK_EN
    ,
    .rd_chan(rd_chan),
    .rd_num (rd_num),
    .rd_den (rd_den)
`endif
  );

  // Small instance: non-power-of-two channel count and saturated default den.
  clk_en_gen #(.CHANNELS(3), .ACC_W(2), .SETTLE_CYCLES(1)) dut2 (
    .refclk (refclk),
    .rst_n  (rst2_n),
    .bus    (bus2)
`ifdef CLK_EN_GEN_READBACK_EN
    ,
    .rd_chan(rd2_chan),
    .rd_num (rd2_num),
    .rd_den (rd2_den)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pulse k fires at phase time t iff floor(t*n/d) steps up.
  longint        m_num [CH];
  longint        m_den [CH];
  bit            m_run, m_apply, m_ce_known;
  int            m_wait;
  longint        m_t;
  int            m_sh_ch;
  longint        m_sh_num, m_sh_den;
  logic [CH-1:0] m_ce;

  typedef struct {
    int chan;
    int num;
    int den;
    int exp_pulses;
    int exp_num;
  } vec_t;
  vec_t vec [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) begin
      m_num[k] = 1;
      m_den[k] = (k >= AW) ? ((longint'(1) << AW) - 1) : (longint'(1) << k);
    end
    m_run = 0; m_apply = 0; m_ce_known = 1; m_wait = SC; m_t = 0; m_ce = '0;
  endfunction

  function automatic logic [CH-1:0] exp_ce(input longint t);
    logic [CH-1:0] e;
    e = '0;
    for (int k = 0; k < CH; k++)
      if (m_num[k] != 0 && m_den[k] != 0)
        e[k] = ((t * m_num[k]) / m_den[k]) > (((t - 1) * m_num[k]) / m_den[k]);
    return e;
  endfunction

  function automatic void model_edge(input bit v, input int ch, input int nm, input int dn, input bit sy);
    m_ce_known = 1;
    if (m_apply) begin
      m_num[m_sh_ch] = (m_sh_num > m_sh_den) ? m_sh_den : m_sh_num;
      m_den[m_sh_ch] = m_sh_den;
      m_apply = 0; m_run = 0; m_wait = SC; m_ce = '0;
    end else if (v && ch < CH) begin
      m_ce_known = !m_run;
      m_apply = 1; m_run = 0; m_ce = '0;
      m_sh_ch = ch; m_sh_num = nm; m_sh_den = dn;
    end else if (m_run) begin
      if (sy) begin
        m_t = 0; m_ce = '0;
      end else begin
        m_t++; m_ce = exp_ce(m_t);
      end
    end else begin
      m_ce = '0;
      if (m_wait == 0) begin
        m_run = 1; m_t = 0;
      end else begin
        m_wait--;
      end
    end
  endfunction

  task automatic step(input bit v, input int ch, input int nm, input int dn, input bit sy);
    bus.cfg_valid = v;
    bus.cfg_chan  = 2'(ch);
    bus.cfg_num   = AW'(nm);
    bus.cfg_den   = AW'(dn);
    bus.sync      = sy;
    @(posedge refclk);
    model_edge(v, ch, nm, dn, sy);
    #1;
    check("locked", int'(bus.locked), int'(m_run));
    check("cfg_ready", int'(bus.cfg_ready), int'(!m_apply));
    if (m_ce_known) check("ce_out", int'(bus.ce_out), int'(m_ce));
    bus.cfg_valid = 1'b0;
    bus.sync      = 1'b0;
  endtask

  task automatic wait_lock(output int edges);
    edges = 0;
    for (int i = 1; i <= 60 && edges == 0; i++) begin
      step(0, 0, 0, 0, 0);
      if (bus.locked) edges = i;
    end
    check("lock_wait", int'(bus.locked), 1);
  endtask

  task automatic run_count(input int n, input int ch, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0);
      cnt += int'(bus.ce_out[2'(ch)]);
    end
  endtask

  task automatic check_defaults(input string tag);
    int c [CH];
    for (int k = 0; k < CH; k++) c[k] = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0);
      for (int k = 0; k < CH; k++) c[k] += int'(bus.ce_out[2'(k)]);
    end
    for (int k = 0; k < CH; k++) check($sformatf("%s_ch%0d_pulses", tag, k), c[k], 8 >> k);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, cnt, lo_rdy, lo_lock, pat, r;
    vec[0] = '{1, 7, 9, 12, 7};
    vec[1] = '{3, 5, 4, 16, 4};
    vec[2] = '{1, 0, 5, 0, 0};
    vec[3] = '{0, 7, 0, 0, 0};
    vec[4] = '{2, 2, 5, 6, 2};
    vec[5] = '{3, 1, 1, 16, 1};

    bus.cfg_valid = 0; bus.cfg_chan = '0; bus.cfg_num = '0; bus.cfg_den = '0; bus.sync = 0;
    bus2.cfg_valid = 0; bus2.cfg_chan = '0; bus2.cfg_num = '0; bus2.cfg_den = '0; bus2.sync = 0;

    #1 rst_n = 1'b0; rst2_n = 1'b0;
    model_reset();
    #2;
    check("rst_ce", int'(bus.ce_out), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_ready", int'(bus.cfg_ready), 1);
    #19 rst_n = 1'b1;

    wait_lock(e);
    check("lock_edge", e, SC + 1);
    check_defaults("dflt");

    // ch2 = 3/8 written in RUN
    step(1, 2, 3, 8, 0);
    lo_rdy  = int'(!bus.cfg_ready);
    lo_lock = int'(!bus.locked);
    for (int i = 0; i < 60 && !bus.locked; i++) begin
      step(0, 0, 0, 0, 0);
      lo_rdy  += int'(!bus.cfg_ready);
      lo_lock += int'(!bus.locked);
    end
    check("ready_low_cycles", lo_rdy, 1);
    check("locked_low_cycles", lo_lock, 18);
    run_count(8000, 2, cnt);
    check("ch2_3of8_rate", cnt, 3000);

    for (int i = 0; i < 6; i++) begin
      step(1, vec[i].chan, vec[i].num, vec[i].den, 0);
      wait_lock(e);
      run_count(16, vec[i].chan, cnt);
      check($sformatf("vec%0d_pulses", i), cnt, vec[i].exp_pulses);
`ifdef CLK_EN_GEN_READBACK_EN
      rd_chan = 2'(vec[i].chan);
      step(0, 0, 0, 0, 0);
      check($sformatf("vec%0d_rd_num", i), int'(rd_num), vec[i].exp_num);
      check($sformatf("vec%0d_rd_den", i), int'(rd_den), vec[i].den);
`endif
    end

    // sync realigns ch1 = 1/3
    step(1, 1, 1, 3, 0);
    wait_lock(e);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("sync_ce", int'(bus.ce_out), 0);
    check("sync_locked", int'(bus.locked), 1);
    pat = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0);
      pat |= int'(bus.ce_out[1]) << i;
    end
    check("sync_ch1_pattern", pat, 36);

    // sync and config on the same edge
    step(1, 0, 1, 4, 1);
    check("synccfg_locked", int'(bus.locked), 0);
    check("synccfg_ready", int'(bus.cfg_ready), 0);
    wait_lock(e);
    run_count(16, 0, cnt);
    check("synccfg_ch0_pulses", cnt, 4);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2)
        step(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      else if (r < 6)
        step(0, 0, 0, 0, 1);
      else
        step(0, 0, 0, 0, 0);
    end

    // asynchronous reset mid-RUN with ch0 running flat out
    step(1, 0, 1, 1, 0);
    wait_lock(e);
    step(0, 0, 0, 0, 0);
    check("prerst_ce0", int'(bus.ce_out[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ce", int'(bus.ce_out), 0);
    check("midrst_locked", int'(bus.locked), 0);
    check("midrst_ready", int'(bus.cfg_ready), 1);
    model_reset();
    #2 rst_n = 1'b1;
    wait_lock(e);
    check("relock_edge", e, SC + 1);
    check_defaults("relock");

    // second instance: saturated default den and out-of-range channel
    #3 rst2_n = 1'b1;
    e = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge refclk); #1;
      if (bus2.locked && e == 0) e = i;
    end
    check("d2_lock_edge", e, 2);
    lo_rdy = 0; lo_lock = 0; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge refclk); #1;
      lo_rdy  += int'(bus2.ce_out[0]);
      lo_lock += int'(bus2.ce_out[1]);
      cnt     += int'(bus2.ce_out[2]);
    end
    check("d2_ch0_pulses", lo_rdy, 12);
    check("d2_ch1_pulses", lo_lock, 6);
    check("d2_ch2_sat_pulses", cnt, 4);
    bus2.cfg_valid = 1'b1; bus2.cfg_chan = 2'd3; bus2.cfg_num = 2'd0; bus2.cfg_den = 2'd1;
    @(posedge refclk); #1;
    bus2.cfg_valid = 1'b0;
    check("d2_oor_ready", int'(bus2.cfg_ready), 1);
    check("d2_oor_locked", int'(bus2.locked), 1);
    lo_lock = 0; lo_rdy = 0; cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge refclk); #1;
      lo_lock += int'(!bus2.locked);
      lo_rdy  += int'(bus2.ce_out[0]);
      cnt     += int'(bus2.ce_out[2]);
    end
    check("d2_oor_unlock_cycles", lo_lock, 0);
    check("d2_oor_ch0_pulses", lo_rdy, 12);
    check("d2_oor_ch2_pulses", cnt, 4);
`ifdef CLK_EN_GEN_READBACK_EN
    rd2_chan = 2'd3;
    @(posedge refclk); #1;
    check("d2_rd_oor_num", int'(rd2_num), 0);
    check("d2_rd_oor_den", int'(rd2_den), 0);
    rd2_chan = 2'd2;
    @(posedge refclk); #1;
    check("d2_rd_ch2_num", int'(rd2_num), 1);
    check("d2_rd_ch2_den", int'(rd2_den), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
